// File: rtl/i2c_target_regs.sv
// I2C target with NREG byte registers, an auto-incrementing pointer and a write strobe.
// Latency: about FILT+3 clk from pin to FSM; no backpressure, the master's SCL paces every transfer.
module i2c_target_regs #(
  parameter logic [6:0] TGT_ADDR = 7'h50,
  parameter int         NREG     = 16,
  parameter int         FILT     = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    scl_i,
  input  logic                    sda_i,
  output logic                    sda_oe,
  output logic                    wr_stb,
  output logic [$clog2(NREG)-1:0] wr_idx,
  output logic [7:0]              wr_dat,
  output logic                    busy
);
  localparam int        AW      = $clog2(NREG);
  localparam logic [7:0] FILT_M1 = 8'(FILT - 1);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ADDR     = 4'd1;
  localparam logic [3:0] ADDR_ACK = 4'd2;
  localparam logic [3:0] PTR      = 4'd3;
  localparam logic [3:0] PTR_ACK  = 4'd4;
  localparam logic [3:0] WDAT     = 4'd5;
  localparam logic [3:0] WDAT_ACK = 4'd6;
  localparam logic [3:0] RDAT     = 4'd7;
  localparam logic [3:0] RDAT_ACK = 4'd8;

  logic [1:0]    scl_sy, sda_sy;
  logic [7:0]    scl_cnt, sda_cnt;
  logic          scl_f, sda_f, scl_q, sda_q;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]    state;
  logic [2:0]    cnt;
  logic [7:0]    sr, tx, byte_nx;
  logic          rw;
  logic [AW-1:0] ptr;
  logic [7:0]    regs [NREG];

  // Levels only move after FILT consecutive samples disagree with the current level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_sy  <= 2'b11;
      sda_sy  <= 2'b11;
      scl_cnt <= '0;
      sda_cnt <= '0;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      scl_sy <= {scl_sy[0], scl_i};
      sda_sy <= {sda_sy[0], sda_i};
      scl_q  <= scl_f;
      sda_q  <= sda_f;
      if (scl_sy[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FILT_M1) begin
        scl_f   <= scl_sy[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 8'd1;
      end
      if (sda_sy[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FILT_M1) begin
        sda_f   <= sda_sy[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 8'd1;
      end
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  assign byte_nx   = {sr[6:0], sda_f};

  // Sampling happens on SCL rise; sda_oe is only updated on SCL fall so it moves while SCL is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      sr     <= '0;
      tx     <= '0;
      rw     <= 1'b0;
      ptr    <= '0;
      sda_oe <= 1'b0;
      wr_stb <= 1'b0;
      wr_idx <= '0;
      wr_dat <= '0;
      busy   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (start_det) begin
        state  <= ADDR;
        cnt    <= '0;
        sda_oe <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        cnt    <= '0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR: begin
            sr  <= byte_nx;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (byte_nx[7:1] == TGT_ADDR) begin
                state <= ADDR_ACK;
                rw    <= byte_nx[0];
                busy  <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          PTR: begin
            sr  <= byte_nx;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              ptr   <= byte_nx[AW-1:0];
              state <= PTR_ACK;
            end
          end
          WDAT: begin
            sr  <= byte_nx;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              regs[ptr] <= byte_nx;
              wr_stb    <= 1'b1;
              wr_idx    <= ptr;
              wr_dat    <= byte_nx;
              ptr       <= ptr + AW'(1);
              state     <= WDAT_ACK;
            end
          end
          ADDR_ACK: begin
            state <= rw ? RDAT : PTR;
            cnt   <= '0;
          end
          PTR_ACK, WDAT_ACK: begin
            state <= WDAT;
            cnt   <= '0;
          end
          RDAT: begin
            tx  <= {tx[6:0], 1'b0};
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              ptr   <= ptr + AW'(1);
              state <= RDAT_ACK;
            end
          end
          RDAT_ACK: begin
            cnt   <= '0;
            state <= sda_f ? IDLE : RDAT;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR_ACK, PTR_ACK, WDAT_ACK: sda_oe <= 1'b1;
          RDAT: begin
            // cnt==0 here is the fall that closes the ACK slot, so fetch the next byte.
            if (cnt == 3'd0) begin
              tx     <= regs[ptr];
              sda_oe <= ~regs[ptr][7];
            end else begin
              sda_oe <= ~tx[7];
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bus-level master drives randomized and directed transactions; a monitor scoreboards
// ACKs, read bytes and register write strobes against a byte-array reference model.
module tb_i2c_target_regs;
  localparam logic [6:0] TGT  = 7'h50;
  localparam int         NREG = 16;
  localparam int         Q    = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_stb, busy;
  logic [3:0] wr_idx;
  logic [7:0] wr_dat;

  assign sda_line = m_sda & ~sda_oe;
  always #5 clk = ~clk;

  i2c_target_regs #(.TGT_ADDR(TGT), .NREG(NREG), .FILT(3)) dut (
    .clk(clk), .resetn(resetn), .scl_i(m_scl), .sda_i(sda_line),
    .sda_oe(sda_oe), .wr_stb(wr_stb), .wr_idx(wr_idx), .wr_dat(wr_dat), .busy(busy)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          stray = 0;
  bit          foreign = 1'b0;
  logic [7:0]  mem [NREG];
  int          ptr;
  int          exp_bus[$];
  string       exp_nm[$];
  int          obs_bus[$];
  logic [11:0] exp_wr[$];
  logic [7:0]  pl[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void expect_bus(input string nm, input int v);
    exp_bus.push_back(v);
    exp_nm.push_back(nm);
  endfunction

  // Monitor: compares strobes and bus responses whenever the DUT or bus presents them.
  initial begin
    forever begin
      @(negedge clk);
      if (wr_stb) begin
        chk("wr_pending", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) begin
          logic [11:0] e;
          e = exp_wr.pop_front();
          chk("wr_idx", wr_idx, e[11:8]);
          chk("wr_dat", wr_dat, e[7:0]);
        end
      end
      if (sda_oe && foreign) stray++;
      while (obs_bus.size() > 0) begin
        int o;
        o = obs_bus.pop_front();
        chk("bus_pending", exp_bus.size() > 0, 1);
        if (exp_bus.size() > 0) chk(exp_nm.pop_front(), o, exp_bus.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  // One SCL period; gl injects a 2-clk inverted SDA pulse while SCL is high.
  task automatic xbit(input logic b, input logic gl, output logic r);
    m_sda = b; tick(Q);
    m_scl = 1'b1; tick(3);
    if (gl) begin
      m_sda = ~b; tick(2); m_sda = b;
    end else begin
      tick(2);
    end
    tick(Q - 5);
    r = sda_line;
    tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic [7:0] gm, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xbit(d[i], gm[i], r);
    xbit(1'b1, 1'b0, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      xbit(1'b1, 1'b0, r);
      d = {d[6:0], r};
    end
    xbit(~mack, 1'b0, r);
  endtask

  // Write transaction of pl[]: first byte is the pointer, the rest are data.
  task automatic do_write(input logic [6:0] a, input bit stop, input logic [7:0] gm);
    logic ack;
    bit   hit;
    hit = (a == TGT);
    foreign = !hit;
    i2c_start;
    expect_bus("addr_ack", int'(hit));
    wr_byte({a, 1'b0}, 8'h00, ack);
    obs_bus.push_back(int'(ack));
    chk("busy_addr", busy, hit);
    for (int i = 0; i < pl.size(); i++) begin
      if (hit) begin
        if (i == 0) begin
          ptr = pl[0] % NREG;
        end else begin
          exp_wr.push_back({4'(ptr), pl[i]});
          mem[ptr] = pl[i];
          ptr = (ptr + 1) % NREG;
        end
      end
      expect_bus(i == 0 ? "ptr_ack" : "data_ack", int'(hit));
      wr_byte(pl[i], gm, ack);
      obs_bus.push_back(int'(ack));
    end
    if (stop) begin
      i2c_stop;
      chk("busy_stop", busy, 0);
      foreign = 1'b0;
    end
  endtask

  task automatic do_read(input int n);
    logic       ack;
    logic [7:0] d;
    i2c_start;
    expect_bus("raddr_ack", 1);
    wr_byte({TGT, 1'b1}, 8'h00, ack);
    obs_bus.push_back(int'(ack));
    for (int i = 0; i < n; i++) begin
      expect_bus("rd_byte", int'(mem[ptr]));
      ptr = (ptr + 1) % NREG;
      rd_byte(i < n - 1, d);
      obs_bus.push_back(int'(d));
    end
    chk("oe_after_nack", sda_oe, 0);
    i2c_stop;
    chk("busy_stop", busy, 0);
  endtask

  initial begin
    logic r;
    logic ack;
    for (int i = 0; i < NREG; i++) mem[i] = 8'h00;
    ptr = 0;
    tick(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_wr_dat", wr_dat, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    tick(10);

    pl = '{8'h03, 8'hA5, 8'h5A};
    do_write(TGT, 1'b1, 8'h00);

    pl = '{8'h03};
    do_write(TGT, 1'b0, 8'h00);
    do_read(3);

    pl = '{8'h03, 8'h77, 8'h12};
    do_write(7'h51, 1'b1, 8'h00);
    chk("stray_oe_foreign", stray, 0);

    pl = '{8'h0F, 8'h11, 8'h22};
    do_write(TGT, 1'b1, 8'h00);
    pl = '{8'h0F};
    do_write(TGT, 1'b0, 8'h00);
    do_read(2);

    // Glitches on both a 1 and a 0 bit must not look like START/STOP.
    pl = '{8'h08, 8'hF0};
    do_write(TGT, 1'b1, 8'h88);

    // STOP after 4 data bits: nothing written, FSM idle.
    pl = '{8'h02};
    do_write(TGT, 1'b0, 8'h00);
    xbit(1'b1, 1'b0, r); xbit(1'b0, 1'b0, r); xbit(1'b1, 1'b0, r); xbit(1'b1, 1'b0, r);
    i2c_stop;
    chk("busy_abort", busy, 0);
    pl = '{8'h02};
    do_write(TGT, 1'b0, 8'h00);
    do_read(1);

    for (int it = 0; it < 12; it++) begin
      int         n;
      logic [6:0] a;
      n = $urandom_range(1, 3);
      pl = {};
      pl.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < n; k++) pl.push_back(8'($urandom_range(0, 255)));
        a = ($urandom_range(0, 3) == 0) ? 7'h2A : TGT;
        do_write(a, 1'b1, 8'h00);
      end else begin
        do_write(TGT, 1'b0, 8'h00);
        do_read(n);
      end
    end

    // Reset in the middle of a read while the target is pulling SDA low.
    pl = '{8'h06, 8'h00};
    do_write(TGT, 1'b1, 8'h00);
    pl = '{8'h06};
    do_write(TGT, 1'b0, 8'h00);
    i2c_start;
    expect_bus("raddr_ack", 1);
    wr_byte({TGT, 1'b1}, 8'h00, ack);
    obs_bus.push_back(int'(ack));
    xbit(1'b1, 1'b0, r);
    chk("oe_before_rst", sda_oe, 1);
    resetn = 1'b0;
    #1;
    chk("oe_async_rst", sda_oe, 0);
    for (int i = 0; i < NREG; i++) mem[i] = 8'h00;
    ptr = 0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(5);
    chk("busy_in_rst", busy, 0);
    resetn = 1'b1;
    tick(10);
    pl = '{8'h03};
    do_write(TGT, 1'b0, 8'h00);
    do_read(3);

    tick(20);
    chk("exp_bus_left", exp_bus.size(), 0);
    chk("exp_wr_left", exp_wr.size(), 0);
    chk("stray_oe_total", stray, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
